// File: rtl/design_select_pkg.sv
// Shared types and defaults for the design-select conditioning stage.
package design_select_pkg;

    localparam int unsigned SEL_W_DFLT = 4;
    localparam logic [SEL_W_DFLT-1:0] DEFAULT_SEL = '0;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        RUN     = 2'd1,
        QUIESCE = 2'd2,
        RESET   = 2'd3
    } state_t;

endpackage

// File: rtl/sel_sync_debounce.sv
// Synchronises the raw pad select and reports when it has held one value long enough.
module sel_sync_debounce
    import design_select_pkg::*;
#(
    parameter int unsigned SEL_W           = SEL_W_DFLT,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [SEL_W-1:0] sel_pad_i,
    output logic [SEL_W-1:0] cand_o,
    output logic             stable_c_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][SEL_W-1:0] sync_q;
    logic [SEL_W-1:0]                  cand_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [CNT_W-1:0]                  cnt_d;
    logic [SEL_W-1:0]                  sel_sync;

    assign sel_sync = sync_q[SYNC_STAGES-1];

    // Count consecutive cycles the synchronised select matches the candidate; saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (sel_sync != cand_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            sync_q <= '0;
            cand_q <= SEL_W'(DEFAULT_SEL);
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sel_pad_i};
            cand_q <= sel_sync;
            cnt_q  <= cnt_d;
        end
    end

    assign cand_o     = cand_q;
    assign stable_c_o = (sel_sync == cand_q) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/design_select_ctrl.sv
// Presents a debounced design select to the mux and sequences each switch:
// pads tristated, then the target design held in reset, then released.
module design_select_ctrl
    import design_select_pkg::*;
#(
    parameter int unsigned SEL_W           = SEL_W_DFLT,
    parameter int unsigned NUM_GPIO        = 34,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned QUIET_CYCLES    = 16,
    parameter int unsigned RESET_CYCLES    = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [SEL_W-1:0]    sel_pad_i,
    input  logic [NUM_GPIO-1:0] gpio_oeb_i,
    output logic [SEL_W-1:0]    sel_o,
    output logic                design_rst_o,
    output logic [NUM_GPIO-1:0] gpio_oeb_o,
    output logic                switching_o
);

    localparam int unsigned QCW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam int unsigned RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [QCW-1:0] QMAX = QCW'(QUIET_CYCLES - 1);
    localparam logic [RCW-1:0] RMAX = RCW'(RESET_CYCLES - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic [QCW-1:0]   qcnt_q, qcnt_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic             rst_q, rst_d;
    logic             sw_q, sw_d;
    logic             force_q, force_d;
    logic [SEL_W-1:0] cand;
    logic             stable;

    sel_sync_debounce #(
        .SEL_W           (SEL_W),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk        (clk),
        .n_rst      (n_rst),
        .sel_pad_i  (sel_pad_i),
        .cand_o     (cand),
        .stable_c_o (stable)
    );

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= ACQUIRE;
            sel_q   <= SEL_W'(DEFAULT_SEL);
            tgt_q   <= SEL_W'(DEFAULT_SEL);
            qcnt_q  <= '0;
            rcnt_q  <= '0;
            rst_q   <= 1'b1;
            sw_q    <= 1'b1;
            force_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            qcnt_q  <= qcnt_d;
            rcnt_q  <= rcnt_d;
            rst_q   <= rst_d;
            sw_q    <= sw_d;
            force_q <= force_d;
        end
    end

    // Next state; the target tracks the newest stable select while pads are quiet.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        qcnt_d  = qcnt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ACQUIRE: begin
                if (stable) begin
                    sel_d   = cand;
                    rcnt_d  = '0;
                    state_d = RESET;
                end
            end
            RUN: begin
                if (stable && (cand != sel_q)) begin
                    tgt_d   = cand;
                    qcnt_d  = '0;
                    state_d = QUIESCE;
                end
            end
            QUIESCE: begin
                if (stable) begin
                    tgt_d = cand;
                end
                if (qcnt_q == QMAX) begin
                    sel_d   = stable ? cand : tgt_q;
                    rcnt_d  = '0;
                    state_d = RESET;
                end else begin
                    qcnt_d = qcnt_q + QCW'(1);
                end
            end
            RESET: begin
                if (rcnt_q == RMAX) begin
                    state_d = RUN;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            default: state_d = ACQUIRE;
        endcase
        rst_d   = (state_d == ACQUIRE) || (state_d == RESET);
        sw_d    = (state_d != RUN);
        force_d = (state_d != RUN);
    end

    assign sel_o        = sel_q;
    assign design_rst_o = rst_q;
    assign switching_o  = sw_q;
    assign gpio_oeb_o   = force_q ? {NUM_GPIO{1'b1}} : gpio_oeb_i;

endmodule

// File: tb/tb_design_select_ctrl.sv
// Randomised bench for design_select_ctrl against a cycle-timeline reference model.
module tb_design_select_ctrl;

    localparam int SEL_W = 4;
    localparam int NG    = 34;
    localparam int SYNC  = 2;
    localparam int DEB   = 1024;
    localparam int QC    = 16;
    localparam int RC    = 16;
    localparam int VW    = SEL_W + 2 + NG;

    logic             clk = 1'b0;
    logic             n_rst = 1'b1;
    logic [SEL_W-1:0] sel_pad = '0;
    logic [NG-1:0]    gpio_in = '0;
    logic [SEL_W-1:0] sel_o;
    logic             design_rst_o;
    logic             switching_o;
    logic [NG-1:0]    gpio_oeb_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: synchroniser delay line, age of the synchronised value,
    // and position inside the switch sequence (-1 when running).
    logic [SEL_W-1:0] m_pipe [SYNC];
    int               m_age = 0;
    bit               m_acq = 1'b1;
    int               m_seq = -1;
    logic [SEL_W-1:0] m_sel = '0;
    logic [SEL_W-1:0] m_tgt = '0;

    design_select_ctrl #(
        .SEL_W           (SEL_W),
        .NUM_GPIO        (NG),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .QUIET_CYCLES    (QC),
        .RESET_CYCLES    (RC)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sel_pad_i    (sel_pad),
        .gpio_oeb_i   (gpio_in),
        .sel_o        (sel_o),
        .design_rst_o (design_rst_o),
        .gpio_oeb_o   (gpio_oeb_o),
        .switching_o  (switching_o)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] exp_vec();
        bit busy;
        busy = m_acq || (m_seq >= 0);
        return {m_sel, m_acq || (m_seq >= QC), busy, busy ? {NG{1'b1}} : gpio_in};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {sel_o, design_rst_o, switching_o, gpio_oeb_o};
    endfunction

    function automatic logic [NG-1:0] rnd_gpio();
        return NG'({$urandom(), $urandom()});
    endfunction

    // Advance DUT and model by one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        logic [SEL_W-1:0] s;
        bit               st;
        s  = m_pipe[SYNC-1];
        st = (m_age >= DEB);
        if (n_rst) begin
            m_acq = 1'b1; m_seq = -1; m_sel = '0; m_tgt = '0;
        end else if (m_acq) begin
            if (st) begin
                m_acq = 1'b0; m_sel = s; m_seq = QC;
            end
        end else if (m_seq < 0) begin
            if (st && (s != m_sel)) begin
                m_seq = 0; m_tgt = s;
            end
        end else if (m_seq < QC) begin
            if (st) m_tgt = s;
            if (m_seq == QC - 1) m_sel = m_tgt;
            m_seq++;
        end else begin
            m_seq = (m_seq == QC + RC - 1) ? -1 : m_seq + 1;
        end
        if (n_rst) begin
            for (int i = 0; i < SYNC; i++) m_pipe[i] = '0;
            m_age = 1;
        end else begin
            for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = sel_pad;
            if (m_pipe[SYNC-1] != s) m_age = 0;
            else if (m_age < DEB) m_age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel_pad = 4'h3;
        gpio_in = rnd_gpio();
        n_rst = 1'b1;
        step();
        step();
        tests_run++;
        if (dut_vec() !== {4'h0, 1'b1, 1'b1, {NG{1'b1}}}) begin
            tests_failed++;
            $display("FAIL reset_values: got %h want %h", dut_vec(), {4'h0, 1'b1, 1'b1, {NG{1'b1}}});
        end
        n_rst = 1'b0;
    endtask

    task automatic test_acquire();
        int load_cyc = -1;
        int run_cyc = -1;
        for (int i = 1; i <= 3000 && run_cyc < 0; i++) begin
            gpio_in = rnd_gpio();
            step();
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL acquire cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (load_cyc < 0 && sel_o === 4'h3) load_cyc = i;
            if (load_cyc >= 0 && switching_o === 1'b0) run_cyc = i;
        end
        tests_run++;
        if (load_cyc != SYNC + DEB + 1) begin
            tests_failed++;
            $display("FAIL acquire_load_time: got %0d want %0d", load_cyc, SYNC + DEB + 1);
        end
        tests_run++;
        if (run_cyc < 0 || run_cyc - load_cyc != RC) begin
            tests_failed++;
            $display("FAIL acquire_reset_len: got %0d want %0d", run_cyc - load_cyc, RC);
        end
    endtask

    task automatic test_glitch();
        sel_pad = 4'h5;
        for (int i = 0; i < DEB + 100 + DEB - 2; i++) begin
            if (i == DEB - 2) sel_pad = 4'h3;
            gpio_in = rnd_gpio();
            step();
            tests_run++;
            if (dut_vec() !== exp_vec() || switching_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if (sel_o !== 4'h3) begin
            tests_failed++;
            $display("FAIL glitch_sel: got %h want 3", sel_o);
        end
    endtask

    task automatic test_switch();
        int n_q = -1;
        int n_l = -1;
        int n_r = -1;
        sel_pad = 4'h5;
        for (int i = 1; i <= 3000 && n_r < 0; i++) begin
            gpio_in = rnd_gpio();
            step();
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL switch cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (n_q < 0 && switching_o === 1'b1) n_q = i;
            if (n_q >= 0 && n_l < 0 && sel_o === 4'h5 && design_rst_o === 1'b1) n_l = i;
            if (n_q >= 0 && n_r < 0 && switching_o === 1'b0) n_r = i;
        end
        tests_run++;
        if (n_q != SYNC + DEB + 1) begin
            tests_failed++;
            $display("FAIL switch_latency: got %0d want %0d", n_q, SYNC + DEB + 1);
        end
        tests_run++;
        if (n_l - n_q != QC) begin
            tests_failed++;
            $display("FAIL switch_quiet_len: got %0d want %0d", n_l - n_q, QC);
        end
        tests_run++;
        if (n_r - n_q != QC + RC) begin
            tests_failed++;
            $display("FAIL switch_total_len: got %0d want %0d", n_r - n_q, QC + RC);
        end
    endtask

    task automatic test_requeue();
        int         started = 0;
        int         rises = 0;
        int         done = 0;
        logic [3:0] first_load = 4'hf;
        logic [3:0] prev_sel;
        logic       prev_sw;
        sel_pad = 4'h3;
        prev_sel = sel_o;
        prev_sw = switching_o;
        for (int i = 1; i <= 5000 && done == 0; i++) begin
            if (started > 0 && started++ == 8) sel_pad = 4'h9;
            gpio_in = rnd_gpio();
            step();
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL requeue cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (switching_o === 1'b1 && prev_sw === 1'b0) begin
                rises++;
                if (started == 0) started = 1;
            end
            if (first_load === 4'hf && sel_o !== prev_sel) first_load = sel_o;
            if (sel_o === 4'h9 && switching_o === 1'b0) done = 1;
            prev_sw = switching_o;
            prev_sel = sel_o;
        end
        tests_run++;
        if (first_load !== 4'h3 || rises != 2 || done == 0) begin
            tests_failed++;
            $display("FAIL requeue_seq: first %h rises %0d done %0d want first 3 rises 2 done 1",
                     first_load, rises, done);
        end
    endtask

    task automatic test_reset_mid();
        for (int phase = 0; phase < 2; phase++) begin
            int hit = 0;
            sel_pad = (phase == 0) ? 4'h5 : 4'h3;
            for (int i = 0; i < 5000 && hit == 0; i++) begin
                gpio_in = rnd_gpio();
                step();
                tests_run++;
                if (dut_vec() !== exp_vec()) begin
                    tests_failed++;
                    $display("FAIL reset_mid ph %0d cyc %0d: got %h want %h", phase, i, dut_vec(), exp_vec());
                end
                if (switching_o === 1'b1 && (phase == 0 || design_rst_o === 1'b1) && m_acq == 1'b0) hit = 1;
            end
            tests_run++;
            if (hit == 0) begin
                tests_failed++;
                $display("FAIL reset_mid_timeout ph %0d: got no switch want switch", phase);
            end
            for (int i = 0; i < 5; i++) step();
            n_rst = 1'b1;
            step();
            n_rst = 1'b0;
            tests_run++;
            if (dut_vec() !== {4'h0, 1'b1, 1'b1, {NG{1'b1}}} || dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL reset_mid_values ph %0d: got %h want %h", phase, dut_vec(), exp_vec());
            end
            for (int i = 0; i < 5000 && switching_o === 1'b1; i++) begin
                step();
                tests_run++;
                if (dut_vec() !== exp_vec()) begin
                    tests_failed++;
                    $display("FAIL reset_mid_recover ph %0d: got %h want %h", phase, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 20; seg++) begin
            int hold;
            sel_pad = SEL_W'($urandom_range(0, 15));
            hold = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, DEB - 1))
                                               : int'($urandom_range(DEB, DEB + 400));
            for (int i = 0; i < hold; i++) begin
                n_rst = ($urandom_range(0, 1999) == 0);
                gpio_in = rnd_gpio();
                step();
                tests_run++;
                if (dut_vec() !== exp_vec()) begin
                    tests_failed++;
                    $display("FAIL random seg %0d cyc %0d: got %h want %h", seg, i, dut_vec(), exp_vec());
                end
                tests_run++;
                if (switching_o === 1'b0 && gpio_oeb_o !== gpio_in) begin
                    tests_failed++;
                    $display("FAIL oeb_passthru seg %0d: got %h want %h", seg, gpio_oeb_o, gpio_in);
                end
            end
        end
        n_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_glitch();
        test_switch();
        test_requeue();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
